tag_flush_ctrl: RTL



---
 rtl/tag_flush_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/tag_flush_ctrl.sv
// tag_flush_ctrl: per-bank tag-store invalidation sequencer.
// Waits for the bank pipeline to drain, then strobes every line index once,
// one line per cycle, and pulses flush_done after the last line.
// Optional build macro TAG_FLUSH_PERF_EN adds the perf_flush_cycles counter.
module tag_flush_ctrl #(
  parameter int LINES_PER_BANK = 64,
  parameter int FLUSH_ON_RESET = 1,
  parameter int LSEL_BITS      = (LINES_PER_BANK > 1) ? $clog2(LINES_PER_BANK) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_req_valid,
  output logic                 flush_req_ready,
  input  logic                 pipe_busy,
  output logic                 pipe_stall,
  output logic                 tag_flush,
  output logic [LSEL_BITS-1:0] tag_addr,
  output logic                 flush_done,
  output logic                 busy
`ifdef TAG_FLUSH_PERF_EN
  ,
  output logic [31:0]          perf_flush_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SWEEP = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [LSEL_BITS-1:0] LAST_LINE = LSEL_BITS'(LINES_PER_BANK - 1);
  localparam state_t               RST_STATE = (FLUSH_ON_RESET != 0) ? SWEEP : IDLE;

  state_t               state;
  state_t               state_nxt;
  logic [LSEL_BITS-1:0] cnt;
  logic [LSEL_BITS-1:0] cnt_nxt;

  // State and line counter registers; reset restarts from line 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic and Moore output decode from registered state/counter.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    flush_req_ready = 1'b0;
    pipe_stall      = 1'b0;
    tag_flush       = 1'b0;
    tag_addr        = '0;
    flush_done      = 1'b0;
    busy            = 1'b1;
    case (state)
      IDLE: begin
        flush_req_ready = 1'b1;
        busy            = 1'b0;
        if (flush_req_valid) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end
      end
      DRAIN: begin
        pipe_stall = 1'b1;
        if (!pipe_busy) begin
          state_nxt = SWEEP;
        end
      end
      SWEEP: begin
        pipe_stall = 1'b1;
        tag_flush  = 1'b1;
        tag_addr   = cnt;
        // The last line ends the sweep; the counter never wraps past it.
        if (cnt == LAST_LINE) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + LSEL_BITS'(1);
        end
      end
      DONE: begin
        flush_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef TAG_FLUSH_PERF_EN
  // Saturating count of cycles the controller holds the pipeline for a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_flush_cycles <= '0;
    end else if (((state == DRAIN) || (state == SWEEP)) && (perf_flush_cycles != '1)) begin
      perf_flush_cycles <= perf_flush_cycles + 32'd1;
    end
  end
`endif

endmodule
